alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered operand-capture stage (ID/EX boundary) that directly feeds the ALU logic unit's `first_op`, `second_op` and `log_sel` inputs.
- Resolves register operands by forwarding from the EX and MEM stages and builds the second operand from an immediate when selected.
- Detects load-use hazards and inserts bubbles.
- Honours cache-miss freezes and branch flushes, including a flush that arrives during a freeze.

Parameters:
- REG_WIDTH, 32, datapath width of register operands and results.
- CNT_WIDTH, 16, width of the saturating hazard counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  decode stage presents an instruction.
- i_rs_addr  in  5  source register A index.
- i_rt_addr  in  5  source register B index.
- i_rs_data  in  REG_WIDTH  register-file read data A.
- i_rt_data  in  REG_WIDTH  register-file read data B.
- i_imm  in  16  instruction immediate.
- i_use_imm  in  1  second operand is the immediate; rt is not read.
- i_imm_zext  in  1  1 = zero-extend the immediate, 0 = sign-extend.
- i_log_sel  in  3  logic-unit operation code, passed through unchanged.
- i_rd_addr  in  5  destination register.
- i_wr_en  in  1  instruction writes the register file.
- i_ex_wr_en  in  1  instruction now in EX writes a register.
- i_ex_rd  in  5  destination register of the EX instruction.
- i_ex_is_load  in  1  EX instruction is a load, so its data is not yet available.
- i_ex_result  in  REG_WIDTH  EX result.
- i_mem_wr_en  in  1  instruction in MEM writes a register.
- i_mem_rd  in  5  destination register of the MEM instruction.
- i_mem_data  in  REG_WIDTH  MEM-stage result.
- i_mem_stall  in  1  cache miss: freeze this stage.
- i_flush  in  1  branch taken: kill the captured instruction.
- o_valid  out  1  registered outputs hold a live instruction.
- o_first_op  out  REG_WIDTH  ALU operand A.
- o_second_op  out  REG_WIDTH  ALU operand B.
- o_log_sel  out  3  ALU operation select.
- o_rd_addr  out  5  registered destination register.
- o_wr_en  out  1  registered write enable, already gated by o_valid.
- o_stall  out  1  combinational; upstream must hold PC and IF/ID this cycle.
- o_hazard_cnt  out  CNT_WIDTH  count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - o_valid, o_wr_en, o_first_op, o_second_op, o_log_sel, o_rd_addr, o_hazard_cnt and the internal flush_pending flag are all 0.
  - o_stall is 0 while in reset.
  - Reset mid-freeze discards the pending flush and all held state.
- Forwarding (combinational, per source operand):
  - Index 0: the value is always 0. No forwarding and no hazard on r0.
  - If i_ex_wr_en and i_ex_rd matches and not i_ex_is_load, use i_ex_result.
  - Otherwise, if i_mem_wr_en and i_mem_rd matches, use i_mem_data.
  - Otherwise use the register-file data. EX has priority over MEM.
- Operand B:
  - If i_use_imm, take the immediate: zero-extended when i_imm_zext=1, sign-extended from bit 15 when 0.
  - Otherwise take the forwarded rt value.
- Load-use hazard (load_use), all of the following true:
  - i_valid and i_ex_wr_en and i_ex_is_load.
  - i_ex_rd != 0.
  - i_ex_rd matches rs, or matches rt while i_use_imm=0.
- o_stall = (load_use & ~flush_eff) | i_mem_stall.
- Per-edge priority, highest first:
  1. i_mem_stall: all outputs hold. If i_flush is also 1, set flush_pending; o_hazard_cnt does not change.
  2. flush_eff = i_flush | flush_pending: capture a bubble (o_valid=0, o_wr_en=0, data outputs hold) and clear flush_pending.
  3. load_use: capture a bubble and increment o_hazard_cnt, saturating at all-ones. The decode instruction is retried next cycle.
  4. Otherwise capture:
     - o_valid = i_valid.
     - o_first_op, o_second_op and o_log_sel from the forwarded or immediate values.
     - o_rd_addr = i_rd_addr.
     - o_wr_en = i_wr_en & i_valid.
- Latency: 1 cycle from decode to ALU inputs; each load-use adds exactly 1 bubble.
- A load followed by a multi-cycle miss does not double-stall: i_mem_stall holds everything, and load_use re-evaluates only once the stall clears.
- When i_valid=0, the stage captures a bubble and raises no hazard.

Test Plan:
- Reset: drive rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- Forward priority: EX writes r5=0x11 and MEM writes r5=0x22, decode reads rs=r5 -> o_first_op=0x11. With the EX write disabled -> 0x22. With rs=r0 and a forward targeting r0 -> 0.
- Immediate: i_imm=0x8001, use_imm=1. zext=1 -> o_second_op=0x00008001. zext=0 -> 0xFFFF8001.
- Load-use: load to r3 in EX, decode reads rt=r3 with use_imm=0 -> o_stall=1 for 1 cycle, a bubble is captured and o_hazard_cnt goes 0->1. With use_imm=1 and rt=r3 -> no stall.
- Freeze and flush: i_mem_stall=1 for 3 cycles with i_flush pulsed in cycle 2 -> outputs unchanged for all 3 cycles, then the first free edge captures a bubble; the following edge captures normally.
- Counter saturation: preload 2^CNT_WIDTH-2 hazards -> count reaches 0xFFFF and stays there on further hazards.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Registered ID/EX operand-capture stage feeding the ALU logic unit.
//   Each cycle it resolves the two source operands and registers them with
//   the logic-unit op code. Operands come from the register file, or are
//   forwarded from EX or MEM. Operand B can instead be an immediate. The
//   stage also handles load-use bubbles, cache-miss freezes and branch
//   flushes. A flush that arrives during a freeze is remembered and applied
//   on the first free edge.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   i_valid                     decode presents an instruction
//   i_rs_addr/i_rt_addr         source register indices
//   i_rs_data/i_rt_data         register-file read data
//   i_imm, i_use_imm, i_imm_zext  immediate and how to use/extend it
//   i_log_sel                   logic-unit op code (passed through)
//   i_rd_addr, i_wr_en          destination register and write enable
//   i_ex_*                      EX-stage writer (result, dest, is_load)
//   i_mem_*                     MEM-stage writer (data, dest)
//   i_mem_stall                 cache miss: freeze this stage
//   i_flush                     branch taken: kill the captured instruction
//   o_valid .. o_wr_en          registered ALU inputs and writeback info
//   o_stall                     combinational hold request to PC and IF/ID
//   o_hazard_cnt                saturating count of load-use bubbles
module alu_operand_stage #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [4:0]           i_rs_addr,
  input  logic [4:0]           i_rt_addr,
  input  logic [REG_WIDTH-1:0] i_rs_data,
  input  logic [REG_WIDTH-1:0] i_rt_data,
  input  logic [15:0]          i_imm,
  input  logic                 i_use_imm,
  input  logic                 i_imm_zext,
  input  logic [2:0]           i_log_sel,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_wr_en,
  input  logic                 i_ex_wr_en,
  input  logic [4:0]           i_ex_rd,
  input  logic                 i_ex_is_load,
  input  logic [REG_WIDTH-1:0] i_ex_result,
  input  logic                 i_mem_wr_en,
  input  logic [4:0]           i_mem_rd,
  input  logic [REG_WIDTH-1:0] i_mem_data,
  input  logic                 i_mem_stall,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [REG_WIDTH-1:0] o_first_op,
  output logic [REG_WIDTH-1:0] o_second_op,
  output logic [2:0]           o_log_sel,
  output logic [4:0]           o_rd_addr,
  output logic                 o_wr_en,
  output logic                 o_stall,
  output logic [CNT_WIDTH-1:0] o_hazard_cnt
);

  logic                 valid_q, valid_d;
  logic [REG_WIDTH-1:0] first_op_q, first_op_d;
  logic [REG_WIDTH-1:0] second_op_q, second_op_d;
  logic [2:0]           log_sel_q, log_sel_d;
  logic [4:0]           rd_addr_q, rd_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [CNT_WIDTH-1:0] hazard_cnt_q, hazard_cnt_d;
  logic                 flush_pending_q, flush_pending_d;

  logic [REG_WIDTH-1:0] rs_fwd, rt_fwd, imm_ext;
  logic                 load_use, flush_eff;

  // r0 is hard-wired to zero, so it never forwards. A load in EX cannot
  // forward because its data does not exist yet, so MEM or the register
  // file is used instead. That value is discarded by the load-use bubble.
  function automatic logic [REG_WIDTH-1:0] fwd_sel(
    input logic [4:0]           idx,
    input logic [REG_WIDTH-1:0] rf_data,
    input logic                 ex_wr_en,
    input logic [4:0]           ex_rd,
    input logic                 ex_is_load,
    input logic [REG_WIDTH-1:0] ex_result,
    input logic                 mem_wr_en,
    input logic [4:0]           mem_rd,
    input logic [REG_WIDTH-1:0] mem_data
  );
    if (idx == 5'd0)                                 return '0;
    else if (ex_wr_en && ex_rd == idx && !ex_is_load) return ex_result;
    else if (mem_wr_en && mem_rd == idx)             return mem_data;
    else                                             return rf_data;
  endfunction

  always_comb begin
    rs_fwd = fwd_sel(i_rs_addr, i_rs_data, i_ex_wr_en, i_ex_rd, i_ex_is_load,
                     i_ex_result, i_mem_wr_en, i_mem_rd, i_mem_data);
    rt_fwd = fwd_sel(i_rt_addr, i_rt_data, i_ex_wr_en, i_ex_rd, i_ex_is_load,
                     i_ex_result, i_mem_wr_en, i_mem_rd, i_mem_data);
    imm_ext = i_imm_zext ? {{(REG_WIDTH-16){1'b0}}, i_imm}
                         : {{(REG_WIDTH-16){i_imm[15]}}, i_imm};

    // rt only counts as a hazard source when it is actually read.
    load_use = i_valid && i_ex_wr_en && i_ex_is_load && (i_ex_rd != 5'd0) &&
               ((i_ex_rd == i_rs_addr) || (!i_use_imm && i_ex_rd == i_rt_addr));
    flush_eff = i_flush | flush_pending_q;

    // Hold outputs by default.
    valid_d         = valid_q;
    first_op_d      = first_op_q;
    second_op_d     = second_op_q;
    log_sel_d       = log_sel_q;
    rd_addr_d       = rd_addr_q;
    wr_en_d         = wr_en_q;
    hazard_cnt_d    = hazard_cnt_q;
    flush_pending_d = flush_pending_q;

    if (i_mem_stall) begin
      // Frozen: remember a flush so it is not lost behind the miss.
      flush_pending_d = flush_pending_q | i_flush;
    end else if (flush_eff) begin
      valid_d         = 1'b0;
      wr_en_d         = 1'b0;
      flush_pending_d = 1'b0;
    end else if (load_use) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
      if (hazard_cnt_q != {CNT_WIDTH{1'b1}}) begin
        hazard_cnt_d = hazard_cnt_q + 1'b1;
      end
    end else begin
      valid_d     = i_valid;
      first_op_d  = rs_fwd;
      second_op_d = i_use_imm ? imm_ext : rt_fwd;
      log_sel_d   = i_log_sel;
      rd_addr_d   = i_rd_addr;
      wr_en_d     = i_wr_en & i_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      first_op_q      <= '0;
      second_op_q     <= '0;
      log_sel_q       <= '0;
      rd_addr_q       <= '0;
      wr_en_q         <= 1'b0;
      hazard_cnt_q    <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      first_op_q      <= first_op_d;
      second_op_q     <= second_op_d;
      log_sel_q       <= log_sel_d;
      rd_addr_q       <= rd_addr_d;
      wr_en_q         <= wr_en_d;
      hazard_cnt_q    <= hazard_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // A flush kills the retried instruction anyway, so no hold is needed for it.
  assign o_stall      = rst_n & ((load_use & ~flush_eff) | i_mem_stall);
  assign o_valid      = valid_q;
  assign o_first_op   = first_op_q;
  assign o_second_op  = second_op_q;
  assign o_log_sel    = log_sel_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_wr_en      = wr_en_q;
  assign o_hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//   Directed test of alu_operand_stage. A behavioural reference model
//   predicts every output. A compare process checks the DUT against it on
//   every falling clock edge. The directed steps also pin key results to
//   hand-computed literals.
module tb_alu_operand_stage;

  localparam int RW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_use_imm, i_imm_zext, i_wr_en;
  logic [4:0]    i_rs_addr, i_rt_addr, i_rd_addr, i_ex_rd, i_mem_rd;
  logic [RW-1:0] i_rs_data, i_rt_data, i_ex_result, i_mem_data;
  logic [15:0]   i_imm;
  logic [2:0]    i_log_sel;
  logic          i_ex_wr_en, i_ex_is_load, i_mem_wr_en, i_mem_stall, i_flush;

  logic          o_valid, o_wr_en, o_stall;
  logic [RW-1:0] o_first_op, o_second_op;
  logic [2:0]    o_log_sel;
  logic [4:0]    o_rd_addr;
  logic [CW-1:0] o_hazard_cnt;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
    .i_use_imm(i_use_imm), .i_imm_zext(i_imm_zext), .i_log_sel(i_log_sel),
    .i_rd_addr(i_rd_addr), .i_wr_en(i_wr_en),
    .i_ex_wr_en(i_ex_wr_en), .i_ex_rd(i_ex_rd), .i_ex_is_load(i_ex_is_load),
    .i_ex_result(i_ex_result),
    .i_mem_wr_en(i_mem_wr_en), .i_mem_rd(i_mem_rd), .i_mem_data(i_mem_data),
    .i_mem_stall(i_mem_stall), .i_flush(i_flush),
    .o_valid(o_valid), .o_first_op(o_first_op), .o_second_op(o_second_op),
    .o_log_sel(o_log_sel), .o_rd_addr(o_rd_addr), .o_wr_en(o_wr_en),
    .o_stall(o_stall), .o_hazard_cnt(o_hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Directed literal check: one line per transaction.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
    $display("txn %-14s actual=0x%08h expected=0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic          m_valid = 0, m_wr = 0, m_fp = 0;
  logic [RW-1:0] m_a = 0, m_b = 0;
  logic [2:0]    m_sel = 0;
  logic [4:0]    m_rd = 0;
  int            m_cnt = 0;

  function automatic logic [RW-1:0] operand(input logic [4:0] idx, input logic [RW-1:0] rf);
    if (idx == 0) return 0;
    if (i_ex_wr_en && !i_ex_is_load && i_ex_rd == idx) return i_ex_result;
    if (i_mem_wr_en && i_mem_rd == idx) return i_mem_data;
    return rf;
  endfunction

  function automatic bit hazard();
    bit reads_rs, reads_rt;
    reads_rs = (i_rs_addr == i_ex_rd);
    reads_rt = !i_use_imm && (i_rt_addr == i_ex_rd);
    return i_valid && i_ex_wr_en && i_ex_is_load && i_ex_rd != 0 && (reads_rs || reads_rt);
  endfunction

  function automatic logic [RW-1:0] immediate();
    int unsigned v;
    v = i_imm;
    if (!i_imm_zext && i_imm >= 16'h8000) v = v + 32'hFFFF0000;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_wr <= 0; m_fp <= 0; m_a <= 0; m_b <= 0;
      m_sel <= 0; m_rd <= 0; m_cnt <= 0;
    end else if (i_mem_stall) begin
      if (i_flush) m_fp <= 1;
    end else if (i_flush || m_fp) begin
      m_valid <= 0; m_wr <= 0; m_fp <= 0;
    end else if (hazard()) begin
      m_valid <= 0; m_wr <= 0;
      m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
    end else begin
      m_valid <= i_valid;
      m_a     <= operand(i_rs_addr, i_rs_data);
      m_b     <= i_use_imm ? immediate() : operand(i_rt_addr, i_rt_data);
      m_sel   <= i_log_sel;
      m_rd    <= i_rd_addr;
      m_wr    <= i_wr_en && i_valid;
    end
  end

  // Compare process: all outputs, every falling edge.
  always @(negedge clk) begin
    bit exp_stall;
    exp_stall = rst_n && ((hazard() && !(i_flush || m_fp)) || i_mem_stall);
    chk("valid", {31'd0, o_valid}, {31'd0, m_valid});
    chk("first_op", o_first_op, m_a);
    chk("second_op", o_second_op, m_b);
    chk("log_sel", {29'd0, o_log_sel}, {29'd0, m_sel});
    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, m_rd});
    chk("wr_en", {31'd0, o_wr_en}, {31'd0, m_wr});
    chk("stall", {31'd0, o_stall}, {31'd0, exp_stall});
    chk("hazard_cnt", {16'd0, o_hazard_cnt}, m_cnt[31:0]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    i_valid = 0; i_rs_addr = 0; i_rt_addr = 0; i_rs_data = 0; i_rt_data = 0;
    i_imm = 0; i_use_imm = 0; i_imm_zext = 0; i_log_sel = 0; i_rd_addr = 0;
    i_wr_en = 0; i_ex_wr_en = 0; i_ex_rd = 0; i_ex_is_load = 0; i_ex_result = 0;
    i_mem_wr_en = 0; i_mem_rd = 0; i_mem_data = 0; i_mem_stall = 0; i_flush = 0;
  endtask

  // A plain register-register instruction with no forwarding.
  task automatic plain(input logic [RW-1:0] a, input logic [RW-1:0] b);
    idle();
    i_valid = 1; i_rs_addr = 5'd1; i_rt_addr = 5'd2; i_rs_data = a; i_rt_data = b;
    i_log_sel = 3'd2; i_rd_addr = 5'd9; i_wr_en = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    lit("rst_valid", {31'd0, o_valid}, 32'd0);
    lit("rst_cnt", {16'd0, o_hazard_cnt}, 32'd0);
    rst_n = 1;

    // Forwarding priority: EX over MEM over the register file.
    idle();
    i_valid = 1; i_rs_addr = 5'd5; i_rs_data = 32'h99; i_log_sel = 3'd3;
    i_rd_addr = 5'd7; i_wr_en = 1;
    i_ex_wr_en = 1; i_ex_rd = 5'd5; i_ex_result = 32'h11;
    i_mem_wr_en = 1; i_mem_rd = 5'd5; i_mem_data = 32'h22;
    tick();
    lit("fwd_ex", o_first_op, 32'h11);
    lit("fwd_valid", {31'd0, o_valid}, 32'd1);
    lit("fwd_wr_en", {31'd0, o_wr_en}, 32'd1);
    lit("fwd_log_sel", {29'd0, o_log_sel}, 32'd3);
    i_ex_wr_en = 0;
    tick();
    lit("fwd_mem", o_first_op, 32'h22);
    i_rs_addr = 5'd0; i_ex_wr_en = 1; i_ex_rd = 5'd0; i_mem_rd = 5'd0;
    tick();
    lit("fwd_r0", o_first_op, 32'h0);

    // Immediate extension.
    idle();
    i_valid = 1; i_use_imm = 1; i_imm = 16'h8001; i_imm_zext = 1;
    tick();
    lit("imm_zext", o_second_op, 32'h0000_8001);
    i_imm_zext = 0;
    tick();
    lit("imm_sext", o_second_op, 32'hFFFF_8001);
    i_valid = 0;
    tick();
    lit("idle_bubble", {31'd0, o_valid}, 32'd0);

    // Load-use on rt: one bubble, then the retried instruction proceeds.
    plain(32'h1234, 32'h5678);
    i_rt_addr = 5'd3; i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_rd = 5'd3;
    #1 lit("lu_stall", {31'd0, o_stall}, 32'd1);
    tick();
    lit("lu_bubble", {31'd0, o_valid}, 32'd0);
    lit("lu_cnt", {16'd0, o_hazard_cnt}, 32'd1);
    i_ex_wr_en = 0; i_ex_is_load = 0;
    i_mem_wr_en = 1; i_mem_rd = 5'd3; i_mem_data = 32'hCAFE;
    #1 lit("lu_released", {31'd0, o_stall}, 32'd0);
    tick();
    lit("lu_retry_b", o_second_op, 32'hCAFE);
    // Immediate form does not read rt: no hazard.
    i_use_imm = 1; i_imm = 16'h0004; i_imm_zext = 1;
    i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_rd = 5'd3; i_mem_wr_en = 0;
    #1 lit("imm_no_stall", {31'd0, o_stall}, 32'd0);
    tick();
    lit("imm_no_cnt", {16'd0, o_hazard_cnt}, 32'd1);

    // Freeze for 3 cycles with a flush pulse in cycle 2.
    plain(32'hAAAA, 32'h1);
    tick();
    lit("frz_pre", o_first_op, 32'hAAAA);
    plain(32'hDEAD, 32'h2);
    i_mem_stall = 1;
    tick();
    lit("frz_c1", o_first_op, 32'hAAAA);
    i_flush = 1;
    tick();
    lit("frz_c2", {31'd0, o_valid}, 32'd1);
    i_flush = 0;
    tick();
    lit("frz_c3", o_first_op, 32'hAAAA);
    plain(32'hBBBB, 32'h3);
    // A load-use hazard is masked by the pending flush.
    i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_rd = 5'd1;
    #1 lit("frz_no_stall", {31'd0, o_stall}, 32'd0);
    tick();
    lit("frz_bubble", {31'd0, o_valid}, 32'd0);
    lit("frz_hold_a", o_first_op, 32'hAAAA);
    i_ex_wr_en = 0; i_ex_is_load = 0;
    tick();
    lit("frz_resume", o_first_op, 32'hBBBB);

    // Reset during a freeze discards the pending flush.
    i_mem_stall = 1; i_flush = 1;
    tick();
    #1 rst_n = 0;
    #1 lit("async_rst_a", o_first_op, 32'h0);
    lit("async_rst_stall", {31'd0, o_stall}, 32'd0);
    lit("async_rst_cnt", {16'd0, o_hazard_cnt}, 32'd0);
    tick();
    rst_n = 1;
    plain(32'h77, 32'h88);
    tick();
    lit("post_rst_valid", {31'd0, o_valid}, 32'd1);

    // Counter saturation: a held load-use retries every cycle.
    plain(32'h1, 32'h2);
    i_ex_wr_en = 1; i_ex_is_load = 1; i_ex_rd = 5'd1;
    for (int i = 0; i < 65534; i++) tick();
    lit("sat_pre", {16'd0, o_hazard_cnt}, 32'hFFFE);
    tick();
    lit("sat_max", {16'd0, o_hazard_cnt}, 32'hFFFF);
    tick(); tick();
    lit("sat_hold", {16'd0, o_hazard_cnt}, 32'hFFFF);

    idle();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
